// File: rtl/gray_rx_decoder.sv
// Receive side of the 4-bit binary-to-Gray link: synchronize, decode, track and report position changes.
// Optional build macro GRAY_STEP_CHECK_EN adds the illegal-jump check (err / err_sticky).
module gray_rx_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_dir,
    output logic [WIDTH-1:0] pos_bin,
    output logic             err,
    output logic             err_sticky,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, PRIME, TRACK} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] b_r;
    logic             change;
    logic             dir_n;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Shortest-path direction: the modular delta is "up" while it is below half the range.
    function automatic logic dir_up(input logic [WIDTH-1:0] nb, input logic [WIDTH-1:0] ob);
        logic [WIDTH-1:0] d;
        d = nb - ob;
        return ~d[WIDTH-1];
    endfunction

    // Synchronizer stage: free-running, independent of en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_s = sync_q[SYNC_STAGES-1];
    assign b_s = gray2bin(g_s);

    // Decode register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_r <= '0;
        end else begin
            b_r <= b_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (en) state_n = PRIME;
            PRIME:   state_n = en ? TRACK : IDLE;
            TRACK:   if (!en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign change = (state == TRACK) && en && (b_r != pos_bin);
    assign dir_n  = dir_up(b_r, pos_bin);

    // Tracking and holding-register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_bin   <= '0;
            out_bin   <= '0;
            out_dir   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == PRIME || change) begin
                pos_bin <= b_r;
            end
            if (change) begin
                out_bin   <= b_r;
                out_dir   <= dir_n;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A set in the same cycle as clr_err takes priority.
            if (change && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] g_r;
    logic             illegal;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) cnt = cnt + 1'b1;
        end
        return cnt;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_r <= '0;
        end else begin
            g_r <= g_s;
        end
    end

    // More than one Gray bit flipped relative to the tracked position
    assign illegal = popcnt(g_r ^ bin2gray(pos_bin)) > CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err <= change && illegal;
            if (change && illegal) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
        end
    end
`else
    assign err        = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Scoreboard bench for gray_rx_decoder: randomized Gray walks checked against a table-driven position model.
module tb_gray_rx_decoder;

    localparam int W  = 4;
    localparam int SS = 2;
`ifdef GRAY_STEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, en, out_ready, clr_err;
    logic [W-1:0] gray_in;
    logic         out_valid, out_dir, err, err_sticky, overrun;
    logic [W-1:0] out_bin, pos_bin;

    gray_rx_decoder #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .en(en), .gray_in(gray_in),
        .out_ready(out_ready), .clr_err(clr_err),
        .out_valid(out_valid), .out_bin(out_bin), .out_dir(out_dir),
        .pos_bin(pos_bin), .err(err), .err_sticky(err_sticky), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] bin;
        logic         dir;
        logic         err;
        int           at;
    } exp_t;

    exp_t         q[$];
    exp_t         me;
    int           checks = 0;
    int           passes = 0;
    bit           mon_en = 1'b0;
    bit           tracking = 1'b0;
    logic [W-1:0] cur_bin = '0;

    // Inverse Gray by exhaustive search: the binary whose Gray code equals g
    function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
        logic [W-1:0] r;
        logic [W-1:0] c;
        r = '0;
        for (int b = 0; b < (1 << W); b++) begin
            c = b[W-1:0];
            if ((c ^ (c >> 1)) == g) r = c;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Drive a new Gray value one step after a rising edge and hold it for 'hold' cycles.
    task automatic apply(input logic [W-1:0] g, input int hold);
        logic [W-1:0] nb;
        logic [W-1:0] d;
        exp_t         e;
        @(posedge clk); #1;
        nb = to_bin(g);
        if (tracking && nb != cur_bin) begin
            d     = nb - cur_bin;
            e.bin = nb;
            e.dir = (int'(d) < (1 << (W - 1)));
            e.err = CHK && ($countones(g ^ to_gray(cur_bin)) > 1);
            e.at  = cyc + SS + 2;
            q.push_back(e);
        end
        if (tracking) cur_bin = nb;
        gray_in = g;
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_bin"}, out_bin, 0);
        check({tag, "_out_dir"}, out_dir, 0);
        check({tag, "_pos_bin"}, pos_bin, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_sticky"}, err_sticky, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // Monitor: every accepted output is matched against the oldest expected change
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL spurious_valid: out_bin %0d presented, nothing expected", out_bin);
            end else begin
                me = q.pop_front();
                check("out_bin", out_bin, me.bin);
                check("out_dir", out_dir, me.dir);
                check("err", err, me.err);
                check("latency_cycle", cyc, me.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] nb;
        int           r;
        bit           seen;

        rst = 1'b1; en = 1'b0; out_ready = 1'b1; clr_err = 1'b0; gray_in = '0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;
        en  = 1'b1;
        mon_en = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_all_zero("idle_hold");
        tracking = 1'b1;

        // Basic up-sweep
        apply(4'b0001, 4);
        apply(4'b0011, 4);
        apply(4'b0010, 4);
        drain();
        check("pos_after_sweep", pos_bin, 3);

        // Wrap both ways and a multi-bit jump
        apply(4'b1000, 4);
        apply(4'b0000, 4);
        apply(4'b1000, 4);
        apply(4'b0000, 4);
        drain();
        check("sticky_after_wraps", err_sticky, CHK);
        pulse_clr();
        check("sticky_cleared_1", err_sticky, 0);
        apply(4'b0110, 4);
        drain();
        check("sticky_after_jump", err_sticky, CHK);
        pulse_clr();
        check("sticky_cleared_2", err_sticky, 0);

        // Random walk: mostly single steps, occasional arbitrary jumps
        repeat (40) begin
            r = $urandom_range(0, 9);
            if (r < 6)      nb = cur_bin + 1'b1;
            else if (r < 9) nb = cur_bin - 1'b1;
            else            nb = W'($urandom_range(0, (1 << W) - 1));
            apply(to_gray(nb), $urandom_range(4, 6));
        end
        drain();
        check("pos_after_random", pos_bin, cur_bin);

        // Overrun: two changes while downstream stalls
        mon_en = 1'b0;
        @(posedge clk); #1 out_ready = 1'b0;
        apply(to_gray(cur_bin + 1'b1), 4);
        apply(to_gray(cur_bin + 1'b1), 6);
        q.delete();
        @(posedge clk); #1;
        check("ovr_valid", out_valid, 1);
        check("ovr_bin", out_bin, cur_bin);
        check("ovr_dir", out_dir, 1);
        check("ovr_flag", overrun, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("ovr_valid_dropped", out_valid, 0);
        check("ovr_flag_held", overrun, 1);
        pulse_clr();
        check("ovr_flag_cleared", overrun, 0);

        // Reset while a change is pending
        @(posedge clk); #1 out_ready = 1'b0;
        apply(to_gray(cur_bin + 1'b1), 1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("pending_before_reset", seen, 1);
        #2 rst = 1'b1; en = 1'b0;
        #1 check_all_zero("midrun_reset");
        q.delete();
        tracking = 1'b0;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        mon_en = 1'b1;
        repeat (6) @(posedge clk);
        #1 en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_valid", out_valid, 0);
        check("post_reset_pos", pos_bin, cur_bin);
        tracking = 1'b1;
        apply(to_gray(cur_bin - 1'b1), 4);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
